iiitb_param_sync_fifo: RTL

//  Parametrised single-clock FIFO; next generation of the team's 8-bit sync FIFO.
//  - Generalised data width and depth.
//  - Adds occupancy count, programmable almost-full/almost-empty flags and

---
 rtl/iiitb_param_sync_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/iiitb_param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define SFIFO_FWFT_EN for first-word-fall-through reads; otherwise oData is a registered read.
module iiitb_param_sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              write,
    input  logic [WIDTH-1:0]  iData,
    input  logic              read,
    output logic [WIDTH-1:0]  oData,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   L_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   L_AF      = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   L_AE      = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   L_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] L_PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    // Flags come only from the registered count, never from read/write.
    assign w_full       = (r_count == L_DEPTH);
    assign w_empty      = (r_count == '0);
    assign w_wr_en      = write && !w_full;
    assign w_rd_en      = read && !w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= L_AF);
    assign almost_empty = (r_count <= L_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is not reset; a reset edge must not accept a write.
    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en) begin
            r_mem[r_wr_ptr] <= iData;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= write && w_full;
            r_underflow <= read && w_empty;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + L_CNT_ONE;
                2'b01:   r_count <= r_count - L_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SFIFO_FWFT_EN
    assign oData = w_empty ? '0 : r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_odata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_odata <= '0;
        end else if (w_rd_en) begin
            r_odata <= r_mem[r_rd_ptr];
        end
    end

    assign oData = r_odata;
`endif

endmodule
